// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer sharing one 8-bit RAM port between fetch and data.
// Optional: define ROUND_ROBIN_EN for alternating grant on simultaneous requests.
module mem_byte_seq #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_num,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, TAIL, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q, addr_q, acc_addr;
    logic [1:0]        cnt_q, last_q, cnt_m1, size_last;
    logic              we_q, own_d_q, sgn_q;
    logic [31:0]       wdata_q, asm_q, if_rdata_q, d_rdata_q;
    logic [31:0]       word_fin, load_word;
    logic              grant_d, req_any;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

    assign req_any = d_req | if_req;

`ifdef ROUND_ROBIN_EN
    // Last granted requester; starts as fetch so data wins the first tie.
    logic last_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (state == IDLE && req_any) begin
            last_d_q <= grant_d;
        end
    end

    assign grant_d = d_req & (~if_req | ~last_d_q);
`else
    assign grant_d = d_req;
`endif

    // Index of the final byte: word 3, half 1, everything else a single byte.
    always_comb begin
        size_last = 2'd0;
        case (d_num)
            3'b000:         size_last = 2'd3;
            3'b001, 3'b010: size_last = 2'd1;
            default:        size_last = 2'd0;
        endcase
    end

    assign acc_addr = base_q + ADDR_W'(cnt_q);
    assign cnt_m1   = cnt_q - 2'd1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = ACCESS;
            ACCESS:  if (cnt_q == last_q) state_nx = we_q ? DONE : TAIL;
            TAIL:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Last byte arrives from the RAM during TAIL; merge it before extending.
    always_comb begin
        word_fin = asm_q;
        word_fin[{last_q, 3'b000} +: 8] = ram_rdata;
        case (last_q)
            2'd3:    load_word = word_fin;
            2'd1:    load_word = sgn_q ? {{16{word_fin[15]}}, word_fin[15:0]}
                                       : {16'h0000, word_fin[15:0]};
            default: load_word = sgn_q ? {{24{word_fin[7]}}, word_fin[7:0]}
                                       : {24'h000000, word_fin[7:0]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            we_q       <= 1'b0;
            own_d_q    <= 1'b0;
            sgn_q      <= 1'b0;
            wdata_q    <= 32'h0;
            asm_q      <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        base_q  <= grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                        own_d_q <= grant_d;
                        we_q    <= grant_d & d_we;
                        wdata_q <= d_wdata;
                        cnt_q   <= 2'd0;
                        last_q  <= grant_d ? size_last : 2'd3;
                        sgn_q   <= grant_d & (d_num == 3'b001 || d_num == 3'b011);
                    end
                end
                ACCESS: begin
                    addr_q <= acc_addr;
                    // Read data lags the address by one cycle.
                    if (cnt_q != 2'd0) asm_q[{cnt_m1, 3'b000} +: 8] <= ram_rdata;
                    if (cnt_q != last_q) cnt_q <= cnt_q + 2'd1;
                end
                TAIL: begin
                    if (own_d_q) d_rdata_q  <= load_word;
                    else         if_rdata_q <= load_word;
                end
                default: ;
            endcase
        end
    end

    assign ram_we    = (state == ACCESS) && we_q;
    assign ram_addr  = (state == ACCESS) ? acc_addr : addr_q;
    assign ram_wdata = ram_we ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign d_done    = (state == DONE) && own_d_q;
    assign if_done   = (state == DONE) && !own_d_q;
    assign d_rdata   = d_rdata_q;
    assign if_rdata  = if_rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: doc/mem_byte_seq.md
Name: mem_byte_seq

Overview:
- Byte-serial load/store sequencer for the CPU's 8-bit-wide, byte-addressed memory.
- Arbitrates the single RAM port between instruction fetch and the data (load/store) requester.
- Walks 1, 2 or 4 consecutive byte addresses per transaction, handles the memory handshake, and assembles or splits 32-bit words.
- Returns sign- or zero-extended load data.

Parameters:
ADDR_W, 13, RAM byte-address width; addresses wrap modulo 2^ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request, level; always a 4-byte read
if_addr  in  32  fetch byte address; bits [ADDR_W-1:0] used
if_done  out  1  one-cycle completion pulse to fetch
if_rdata  out  32  fetched word
d_req  in  1  data request, level
d_we  in  1  1 = store, 0 = load
d_num  in  3  size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
d_addr  in  32  data byte address; bits [ADDR_W-1:0] used
d_wdata  in  32  store data; low bytes used for half/byte
d_done  out  1  one-cycle completion pulse to data side
d_rdata  out  32  extended load result
ram_addr  out  ADDR_W  RAM byte address
ram_we  out  1  RAM byte write enable
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read byte; synchronous, valid the cycle after ram_addr
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, including ram_we, done pulses, rdata registers and ram_addr. Reset mid-transaction aborts it immediately. Bytes already written stay written. No done pulse is issued.
- FSM states: IDLE, ACCESS, TAIL, DONE.
- IDLE:
  - Grant priority: d_req wins over if_req.
  - On grant, latch base address, byte count (4/2/1 from size; d_num 101–111 treated as byte unsigned), we, wdata and owner.
  - Clear cnt, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive ram_addr = base + cnt, truncated to ADDR_W, so the address wraps.
  - Store: ram_we = 1 and ram_wdata = wdata[8*cnt+7 : 8*cnt] (little-endian).
  - Load: when cnt >= 1, capture ram_rdata into byte cnt-1.
  - If cnt == last, stores go to DONE and loads go to TAIL; otherwise cnt increments.
- TAIL (loads only):
  - Capture ram_rdata into the last byte; ram_we = 0.
  - Go to DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle.
  - For loads, update the owner's rdata register in the same cycle as done:
    - Word: as assembled.
    - Half: bits [15:0] extended per d_num.
    - Byte: bits [7:0] extended per d_num.
  - Stores leave d_rdata unchanged.
  - The rdata registers hold their value until the next load completion for that owner.
  - Next state is IDLE.
- Requester handshake:
  - Hold req plus all operands stable until done is seen.
  - Deassert req on the same edge that done is seen.
  - A req still high in the following IDLE cycle is a new transaction.
- Latency, counted from the IDLE cycle in which the request is sampled to done high:
  - Word load: 6 cycles.
  - Half load: 4 cycles.
  - Byte load: 3 cycles.
  - Word store: 5 cycles.
  - Half store: 3 cycles.
  - Byte store: 2 cycles.
- Signals outside ACCESS: ram_we is 0 in every state other than ACCESS-with-store. ram_addr holds its last value outside ACCESS.
- Alignment: no checks; unaligned accesses are legal.
- Requests arriving while busy are ignored until IDLE.

Optional Feature:
ROUND_ROBIN_EN
- Defined: when both requests are pending in IDLE, the requester not granted last wins. The "last owner" register resets to fetch, so data wins the first tie.
- Undefined: fixed data-over-fetch priority; fetch can starve under continuous d_req.

Test Plan:
- Initial RAM contents for all scenarios: 0x010=0x11, 0x011=0x22, 0x012=0x83, 0x013=0x44.
- Word load, d_num=000, addr 0x010 -> d_rdata=0x44832211; d_done pulses 6 cycles after the sampling IDLE cycle; if_done stays 0.
- Sub-word loads:
  - lb 0x012 -> 0xFFFFFF83
  - lbu 0x012 -> 0x00000083
  - lh 0x011 -> 0xFFFF8322
  - lhu 0x011 -> 0x00008322
- Store sw 0xDEADBEEF at 0x1FFE (ADDR_W=13):
  - RAM 0x1FFE=EF, 0x1FFF=BE, 0x0000=AD, 0x0001=DE.
  - ram_we high for exactly 4 consecutive cycles.
  - d_done 5 cycles after sampling.
- Byte store sb with d_wdata 0x1234565A at 0x020 -> only 0x020=0x5A; ram_we high 1 cycle; d_rdata unchanged.
- Tie: if_req (0x010) and d_req (lbu 0x013) rise in the same cycle:
  - Data served first, returning 0x00000044.
  - Fetch is granted in the IDLE after DONE, returning 0x44832211.
  - With ROUND_ROBIN_EN and d_req re-asserted immediately, fetch is still granted next.
- Reset: assert rst during the 3rd ACCESS cycle of sw 0xAABBCCDD at 0x030 -> ram_we and busy drop asynchronously; 0x030=DD and 0x031=CC written; 0x032 and 0x033 untouched; no d_done pulse.
